// File: rtl/wbu_commit_stage.sv
// -----------------------------------------------------------------------------
// wbu_commit_stage
//   Write-back / commit stage sitting directly behind execute. Retires one
//   instruction per cycle into the GPR file and the machine-mode CSRs, takes
//   ecall / mret / fence.i, and emits a registered one-cycle flush with a
//   fetch redirect target. Decode gets combinational GPR and CSR read ports.
//
//   Optional build macro WBU_PERF_CSR_EN adds 64-bit mcycle / minstret
//   counters at 0xB00/0xB80 and 0xB02/0xB82. Without it those addresses read 0.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   in_ready          always 1
//   in_valid, in_pc   retiring instruction and its PC
//   in_gpr_waddr/wdata  GPR write (waddr 0 = no write)
//   in_csr_wen/waddr/wdata  CSR write
//   in_exc/in_ret/in_fencei  ecall, mret, fence.i (priority in that order)
//   gpr_raddr1/2, gpr_rdata1/2  combinational GPR reads (no bypass)
//   csr_raddr, csr_rdata        combinational CSR read
//   flush, redirect_pc, fencei_req  registered one-cycle redirect
// -----------------------------------------------------------------------------
module wbu_commit_stage #(
  parameter logic [31:0] RESET_PC  = 32'h3000_0000,
  parameter logic [31:0] MVENDORID = 32'h7973_7978,
  parameter logic [31:0] MARCHID   = 32'h0160_AC2B
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_gpr_waddr,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_csr_wen,
  input  logic [11:0] in_csr_waddr,
  input  logic [31:0] in_csr_wdata,
  input  logic        in_exc,
  input  logic        in_ret,
  input  logic        in_fencei,
  input  logic [4:0]  gpr_raddr1,
  input  logic [4:0]  gpr_raddr2,
  output logic [31:0] gpr_rdata1,
  output logic [31:0] gpr_rdata2,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        fencei_req
);

  localparam int PC_W = $bits(RESET_PC);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
`ifdef WBU_PERF_CSR_EN
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
`endif

  assign in_ready = 1'b1;

  // Anything arriving during the flush cycle is younger than the trap and dropped.
  logic commit, do_exc, do_ret, do_fencei, csr_we;
  assign commit    = in_valid & ~flush;
  assign do_exc    = commit & in_exc;
  assign do_ret    = commit & in_ret & ~in_exc;
  assign do_fencei = commit & in_fencei & ~in_exc & ~in_ret;
  assign csr_we    = commit & in_csr_wen;

  logic [PC_W-1:0] seq_pc;
  assign seq_pc = in_pc + 32'd4;

  // ---------------------------------------------------------------------------
  // GPR file (contents not reset; x0 never written, forced to 0 on read)
  // ---------------------------------------------------------------------------
  logic [31:0] gpr [0:31];

  always_ff @(posedge clock) begin
    if (commit && in_gpr_waddr != 5'd0)
      gpr[in_gpr_waddr] <= in_gpr_wdata;
  end

  assign gpr_rdata1 = (gpr_raddr1 == 5'd0) ? 32'd0 : gpr[gpr_raddr1];
  assign gpr_rdata2 = (gpr_raddr2 == 5'd0) ? 32'd0 : gpr[gpr_raddr2];

  // ---------------------------------------------------------------------------
  // Machine CSRs. MPP is hardwired to 3, so only MIE/MPIE are stored.
  // ---------------------------------------------------------------------------
  logic        mie, mpie;
  logic [31:0] mtvec, mepc, mcause;

  always_ff @(posedge clock) begin
    if (reset) begin
      mie         <= 1'b0;
      mpie        <= 1'b0;
      mtvec       <= 32'd0;
      mepc        <= 32'd0;
      mcause      <= 32'd0;
      flush       <= 1'b0;
      fencei_req  <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      // Trap updates win over a same-cycle software write of the same field.
      if (do_exc) begin
        mie  <= 1'b0;
        mpie <= mie;
      end else if (do_ret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (csr_we && in_csr_waddr == CSR_MSTATUS) begin
        mie  <= in_csr_wdata[3];
        mpie <= in_csr_wdata[7];
      end

      if (csr_we && in_csr_waddr == CSR_MTVEC)
        mtvec <= in_csr_wdata;

      if (do_exc)
        mepc <= in_pc;
      else if (csr_we && in_csr_waddr == CSR_MEPC)
        mepc <= {in_csr_wdata[31:2], 2'b00};

      if (do_exc)
        mcause <= 32'd11;
      else if (csr_we && in_csr_waddr == CSR_MCAUSE)
        mcause <= in_csr_wdata;

      // Redirect targets use CSR values as they stood before this commit.
      flush      <= do_exc | do_ret | do_fencei;
      fencei_req <= do_fencei;
      if (do_exc)
        redirect_pc <= {mtvec[31:2], 2'b00};
      else if (do_ret)
        redirect_pc <= mepc;
      else if (do_fencei)
        redirect_pc <= seq_pc;
    end
  end

`ifdef WBU_PERF_CSR_EN
  // ---------------------------------------------------------------------------
  // Performance counters. A software write replaces only the written half's
  // increment for that cycle; the other half still advances.
  // ---------------------------------------------------------------------------
  logic [63:0] mcycle, minstret, mcycle_nx, minstret_nx;

  always_comb begin
    mcycle_nx   = mcycle + 64'd1;
    minstret_nx = minstret + {63'd0, commit};
    if (csr_we) begin
      case (in_csr_waddr)
        CSR_MCYCLE:    mcycle_nx[31:0]    = in_csr_wdata;
        CSR_MCYCLEH:   mcycle_nx[63:32]   = in_csr_wdata;
        CSR_MINSTRET:  minstret_nx[31:0]  = in_csr_wdata;
        CSR_MINSTRETH: minstret_nx[63:32] = in_csr_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else begin
      mcycle   <= mcycle_nx;
      minstret <= minstret_nx;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // CSR read port
  // ---------------------------------------------------------------------------
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MVENDORID: csr_rdata = MVENDORID;
      CSR_MARCHID:   csr_rdata = MARCHID;
`ifdef WBU_PERF_CSR_EN
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
`endif
      default:       csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_wbu_commit_stage.sv
// -----------------------------------------------------------------------------
// tb_wbu_commit_stage
//   Directed steps followed by a random retirement stream, all checked against
//   an architectural model of the commit stage held in the bench.
// -----------------------------------------------------------------------------
module tb_wbu_commit_stage;

  logic        clock, reset, in_ready;
  logic        in_valid, in_csr_wen, in_exc, in_ret, in_fencei;
  logic [31:0] in_pc, in_gpr_wdata, in_csr_wdata;
  logic [4:0]  in_gpr_waddr, gpr_raddr1, gpr_raddr2;
  logic [11:0] in_csr_waddr, csr_raddr;
  logic [31:0] gpr_rdata1, gpr_rdata2, csr_rdata, redirect_pc;
  logic        flush, fencei_req;

  wbu_commit_stage dut (
    .clock(clock), .reset(reset), .in_ready(in_ready),
    .in_valid(in_valid), .in_pc(in_pc),
    .in_gpr_waddr(in_gpr_waddr), .in_gpr_wdata(in_gpr_wdata),
    .in_csr_wen(in_csr_wen), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
    .in_exc(in_exc), .in_ret(in_ret), .in_fencei(in_fencei),
    .gpr_raddr1(gpr_raddr1), .gpr_raddr2(gpr_raddr2),
    .gpr_rdata1(gpr_rdata1), .gpr_rdata2(gpr_rdata2),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .flush(flush), .redirect_pc(redirect_pc), .fencei_req(fencei_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Architectural model
  logic [31:0] m_gpr [32];
  bit          m_gw  [32];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_redir;
  logic        m_flush, m_fencei;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] csr_exp(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hF11: return 32'h7973_7978;
      12'hF12: return 32'h0160_AC2B;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mstatus = 32'h0000_1800;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0;
    m_redir = 0; m_flush = 0; m_fencei = 0;
  endtask

  // Apply the currently driven inputs to the model as one clock edge.
  task automatic model_step();
    logic [31:0] o_ms, o_tv, o_ep;
    logic nf, nfi;
    o_ms = m_mstatus; o_tv = m_mtvec; o_ep = m_mepc;
    nf = 0; nfi = 0;
    if (in_valid && !m_flush) begin
      if (in_gpr_waddr != 0) begin
        m_gpr[in_gpr_waddr] = in_gpr_wdata;
        m_gw[in_gpr_waddr]  = 1;
      end
      if (in_csr_wen) begin
        case (in_csr_waddr)
          12'h300: m_mstatus = 32'h1800 | (in_csr_wdata & 32'h88);
          12'h305: m_mtvec   = in_csr_wdata;
          12'h341: m_mepc    = in_csr_wdata & ~32'd3;
          12'h342: m_mcause  = in_csr_wdata;
          default: ;
        endcase
      end
      if (in_exc) begin
        m_mepc = in_pc; m_mcause = 11;
        m_mstatus = 32'h1800 | ((o_ms & 32'h8) << 4);
        m_redir = o_tv & ~32'd3; nf = 1;
      end else if (in_ret) begin
        m_mstatus = 32'h1880 | ((o_ms & 32'h80) >> 4);
        m_redir = o_ep; nf = 1;
      end else if (in_fencei) begin
        m_redir = in_pc + 32'd4; nf = 1; nfi = 1;
      end
    end
    m_flush = nf; m_fencei = nfi;
  endtask

  task automatic idle();
    in_valid = 0; in_pc = 0; in_gpr_waddr = 0; in_gpr_wdata = 0;
    in_csr_wen = 0; in_csr_waddr = 0; in_csr_wdata = 0;
    in_exc = 0; in_ret = 0; in_fencei = 0;
  endtask

  // Called at a negedge with inputs set: check reads, clock once, check outputs.
  task automatic tick();
    #1;
    if (gpr_raddr1 == 0 || m_gw[gpr_raddr1]) chk("gpr_rd1", gpr_rdata1, (gpr_raddr1 == 0) ? 32'd0 : m_gpr[gpr_raddr1]);
    if (gpr_raddr2 == 0 || m_gw[gpr_raddr2]) chk("gpr_rd2", gpr_rdata2, (gpr_raddr2 == 0) ? 32'd0 : m_gpr[gpr_raddr2]);
    chk("csr_rd", csr_rdata, csr_exp(csr_raddr));
    model_step();
    @(posedge clock);
    @(negedge clock);
    chk("flush", 32'(flush), 32'(m_flush));
    chk("fencei_req", 32'(fencei_req), 32'(m_fencei));
    if (m_flush) chk("redirect_pc", redirect_pc, m_redir);
  endtask

  task automatic peek_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_raddr = a; #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic commit_gpr(input logic [4:0] a, input logic [31:0] d);
    idle(); in_valid = 1; in_gpr_waddr = a; in_gpr_wdata = d; tick(); idle();
  endtask

  localparam int NCSR = 11;
  logic [11:0] csr_list [NCSR] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11,
                                   12'hF12, 12'hB00, 12'hB80, 12'hB02, 12'h123, 12'h300};

  logic [31:0] x7_saved;

  initial begin
    for (int i = 0; i < 32; i++) begin m_gpr[i] = 0; m_gw[i] = 0; end
    idle();
    gpr_raddr1 = 0; gpr_raddr2 = 0; csr_raddr = 12'h300;
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();

    // Reset state
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_fencei", 32'(fencei_req), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    peek_csr("rst_mstatus", 12'h300, 32'h0000_1800);
    peek_csr("rst_mtvec", 12'h305, 32'd0);
    peek_csr("rst_mepc", 12'h341, 32'd0);
    peek_csr("rst_mcause", 12'h342, 32'd0);
    peek_csr("mvendorid", 12'hF11, 32'h7973_7978);
    peek_csr("marchid", 12'hF12, 32'h0160_AC2B);

    // Basic GPR write / read and x0
    commit_gpr(5'd5, 32'hDEAD_BEEF);
    gpr_raddr1 = 5; #1; chk("x5_read", gpr_rdata1, 32'hDEAD_BEEF);
    commit_gpr(5'd0, 32'd1);
    gpr_raddr1 = 0; #1; chk("x0_read", gpr_rdata1, 32'd0);

    // Fill remaining registers so every later read is defined
    for (int r = 1; r < 32; r++) commit_gpr(5'(r), $urandom);

    // mtvec write then ecall
    in_valid = 1; in_csr_wen = 1; in_csr_waddr = 12'h305; in_csr_wdata = 32'h8000_0103; tick(); idle();
    in_valid = 1; in_exc = 1; in_pc = 32'h8000_0010; tick(); idle();
    chk("exc_flush", 32'(flush), 32'd1);
    chk("exc_redirect", redirect_pc, 32'h8000_0100);
    peek_csr("exc_mepc", 12'h341, 32'h8000_0010);
    peek_csr("exc_mcause", 12'h342, 32'd11);
    peek_csr("exc_mstatus", 12'h300, 32'h0000_1800);
    tick();
    chk("exc_flush_drop", 32'(flush), 32'd0);

    // mstatus MIE=1, ecall, mret
    in_valid = 1; in_csr_wen = 1; in_csr_waddr = 12'h300; in_csr_wdata = 32'h8; tick(); idle();
    peek_csr("ms_mie", 12'h300, 32'h0000_1808);
    in_valid = 1; in_exc = 1; in_pc = 32'h0000_4444; tick(); idle();
    chk("ecall2_redirect", redirect_pc, 32'h8000_0100);
    peek_csr("ecall2_mstatus", 12'h300, 32'h0000_1880);
    tick();
    in_valid = 1; in_ret = 1; in_pc = 32'h8000_0120; tick(); idle();
    chk("mret_flush", 32'(flush), 32'd1);
    chk("mret_redirect", redirect_pc, 32'h0000_4444);
    peek_csr("mret_mstatus", 12'h300, 32'h0000_1888);
    tick();

    // fence.i wrap, and a commit attempt during the flush cycle
    x7_saved = m_gpr[7];
    in_valid = 1; in_fencei = 1; in_pc = 32'hFFFF_FFFC; tick(); idle();
    chk("fi_flush", 32'(flush), 32'd1);
    chk("fi_req", 32'(fencei_req), 32'd1);
    chk("fi_redirect", redirect_pc, 32'd0);
    in_valid = 1; in_gpr_waddr = 7; in_gpr_wdata = ~x7_saved; in_exc = 1; tick(); idle();
    chk("fi_flush_end", 32'(flush), 32'd0);
    chk("fi_req_end", 32'(fencei_req), 32'd0);
    gpr_raddr1 = 7; #1; chk("x7_unchanged", gpr_rdata1, x7_saved);

    // Counters absent in default build
    peek_csr("mcycle_absent", 12'hB00, 32'd0);
    peek_csr("minstret_absent", 12'hB02, 32'd0);

    // Random retirement stream
    for (int n = 0; n < 600; n++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_pc        = $urandom;
      in_gpr_waddr = 5'($urandom_range(0, 31));
      in_gpr_wdata = $urandom;
      in_csr_wen   = ($urandom_range(0, 2) == 0);
      in_csr_waddr = csr_list[$urandom_range(0, NCSR - 1)];
      in_csr_wdata = $urandom;
      in_exc       = ($urandom_range(0, 9) == 0);
      in_ret       = ($urandom_range(0, 9) == 0);
      in_fencei    = ($urandom_range(0, 9) == 0);
      gpr_raddr1   = 5'($urandom_range(0, 31));
      gpr_raddr2   = 5'($urandom_range(0, 31));
      csr_raddr    = csr_list[$urandom_range(0, NCSR - 1)];
      tick();
    end

    // Reset while a flush is pending clears it on the next edge
    idle();
    in_valid = 1; in_fencei = 1; in_pc = 32'h100; reset = 1;
    @(posedge clock); @(negedge clock);
    model_reset();
    reset = 0; idle();
    chk("rst_mid_flush", 32'(flush), 32'd0);
    peek_csr("rst_mid_mstatus", 12'h300, 32'h0000_1800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
